uart_bram_rd_arbiter: RTL
=========================

Name: uart_bram_rd_arbiter

Overview:
- Shares one BRAM read port among NUM_CH UART TX channels.
- Each channel requests a burst of frame words (start address + length). The block grants channels round-robin, drives the BRAM read port one word per cycle, and returns the read data tagged with the channel index.
- Sits between the per-channel UART TX fetch logic and the EMIF-side TX frame BRAM port B.

Parameters:
- NUM_CH, 4, number of requesting UART channels (2..8).
- ADDR_W, 16, BRAM word address width.
- DATA_W, 16, BRAM data width.
- LEN_W, 8, burst length width in words.
- RD_LAT, 2, BRAM read latency in cycles from o_BRAM_EN to valid i_BRAM_Dout (1..4).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_Req  in  NUM_CH  per-channel burst request level.
- i_Addr  in  NUM_CH*ADDR_W  per-channel start address; channel n is at [n*ADDR_W +: ADDR_W].
- i_Len  in  NUM_CH*LEN_W  per-channel burst length in words.
- o_Grant  out  NUM_CH  one-hot; the channel currently served.
- o_Done  out  NUM_CH  one-cycle pulse when a burst completes.
- o_Len_ERR  out  NUM_CH  one-cycle pulse when a burst is rejected because length is 0.
- o_BRAM_EN  out  1  BRAM read enable.
- o_BRAM_Addr  out  ADDR_W  BRAM read address.
- i_BRAM_Dout  in  DATA_W  BRAM read data.
- o_Rd_Data  out  DATA_W  returned word (registered).
- o_Rd_Vld  out  1  o_Rd_Data valid.
- o_Rd_Ch  out  $clog2(NUM_CH)  channel index of o_Rd_Data.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; round-robin pointer set so channel 0 has the highest priority; valid pipeline cleared.
- Reset mid-burst: the burst is aborted with no o_Done. Reads already in flight are discarded, so o_Rd_Vld stays 0.
- FSM states:
  - IDLE: if any i_Req is set, select a channel with the round-robin search. The search starts at (last_served+1) mod NUM_CH. Latch that channel's i_Addr and i_Len, then go to ISSUE, or to ERR if the length is 0.
  - ISSUE: o_Grant is one-hot on the selected channel. o_BRAM_EN=1 and o_BRAM_Addr = start+k for k=0..len-1, one word per cycle. After the last read goes to DRAIN.
  - DRAIN: o_BRAM_EN=0. Waits until the last word returns.
  - ERR: pulse o_Len_ERR[ch] for 1 cycle with o_Grant=0, update last_served=ch, return to IDLE.
- Timing: request seen in IDLE at cycle t. o_Grant and the first o_BRAM_EN are at t+1. The last o_BRAM_EN is at t+len.
- Read return path: a valid shift register RD_LAT+1 deep tracks o_BRAM_EN. o_Rd_Vld/o_Rd_Data/o_Rd_Ch appear RD_LAT+1 cycles after the matching o_BRAM_EN; the extra cycle is the output register. Words are in address order, with no gaps inside a burst.
- Completion: o_Done[ch] pulses in the same cycle as the last o_Rd_Vld of the burst. o_Grant clears the next cycle and last_served=ch. The FSM returns to IDLE, so there is at least a 1-cycle bubble between bursts.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFF+1 wraps to 0x0000 with no error.
- i_Len is unsigned, so the maximum burst is 2^LEN_W-1 words.
- Request rules:
  - i_Addr and i_Len are sampled only in the IDLE selection cycle; later changes are ignored.
  - Deasserting i_Req mid-burst has no effect; the burst completes.
  - If i_Req is still high after o_Done, it is treated as a new request and competes under round-robin, so the just-served channel has the lowest priority.
- Simultaneous requests: exactly one grant per arbitration.

Decomposition:
- Package uart_bram_arb_pkg holds:
  - FSM state enum (IDLE, ISSUE, DRAIN, ERR);
  - default NUM_CH/ADDR_W/DATA_W/LEN_W/RD_LAT constants;
  - a function computing channel index width.
- Sub-module uart_rr_arbiter:
  - takes the request vector and the last-served index;
  - returns a one-hot grant and the index (combinational);
  - the pointer register lives in the parent.

Test Plan:
- RD_LAT=2, ch0 req, addr 0x0010, len 4 ->
  - o_BRAM_Addr 0x10..0x13 on cycles t+1..t+4;
  - o_Rd_Vld on t+4..t+7, Rd_Ch=0, data = BRAM[0x10..0x13];
  - o_Done[0] at t+7; o_Grant[0] clears at t+8.
- All four channels held high from reset, each len 2 -> served in order 0,1,2,3. After ch3's o_Done the order repeats 0,1,2,3, and o_Grant is never multi-hot.
- ch2 len 0, ch3 len 3 simultaneously after last_served=1 -> o_Len_ERR[2] pulse with no BRAM reads, then ch3 burst of 3 words, o_Done[3].
- ch1 addr 0xFFFE, len 4 -> addresses FFFE, FFFF, 0000, 0001; 4 valid words; o_Done[1].
- ch0 len 8: drop i_Req after the 2nd read and change i_Addr -> all 8 words from the original address are returned, then o_Done[0].
- rst asserted during the 3rd read of a len-8 burst -> next cycle all outputs 0, no o_Rd_Vld or o_Done afterwards. A subsequent ch1 request is granted at t+1.

Source files
------------

// File: rtl/uart_bram_rd_arbiter_pkg.sv
// Shared types and defaults for the UART TX BRAM read arbiter.
// FSM encoding and channel-index width helper.
package uart_bram_arb_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = 8;
    localparam int RD_LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        ERR
    } arb_state_t;

    function automatic int ch_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_bram_rd_arbiter_if.sv
// Channel request bus plus BRAM port B read bus for the arbiter.
// slave = arbiter side, master = channels/BRAM side.
interface uart_bram_rd_arbiter_if
    import uart_bram_arb_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
);
    localparam int CH_W = ch_width(NUM_CH);

    logic [NUM_CH-1:0]        i_Req;
    logic [NUM_CH*ADDR_W-1:0] i_Addr;
    logic [NUM_CH*LEN_W-1:0]  i_Len;
    logic [NUM_CH-1:0]        o_Grant;
    logic [NUM_CH-1:0]        o_Done;
    logic [NUM_CH-1:0]        o_Len_ERR;
    logic                     o_BRAM_EN;
    logic [ADDR_W-1:0]        o_BRAM_Addr;
    logic [DATA_W-1:0]        i_BRAM_Dout;
    logic [DATA_W-1:0]        o_Rd_Data;
    logic                     o_Rd_Vld;
    logic [CH_W-1:0]          o_Rd_Ch;

    modport slave (
        input  i_Req, i_Addr, i_Len, i_BRAM_Dout,
        output o_Grant, o_Done, o_Len_ERR,
        output o_BRAM_EN, o_BRAM_Addr,
        output o_Rd_Data, o_Rd_Vld, o_Rd_Ch
    );

    modport master (
        output i_Req, i_Addr, i_Len, i_BRAM_Dout,
        input  o_Grant, o_Done, o_Len_ERR,
        input  o_BRAM_EN, o_BRAM_Addr,
        input  o_Rd_Data, o_Rd_Vld, o_Rd_Ch
    );

endinterface

// File: rtl/uart_bram_rd_arbiter_rr_arbiter.sv
// Combinational round-robin pick; search starts one past last served.
// The pointer register is owned by the caller.
module uart_rr_arbiter
    import uart_bram_arb_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx,
    output logic              any
);

    always_comb begin
        logic [CH_W-1:0] c;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            c = CH_W'((int'(last) + i) % NUM_CH);
            if (!any && req[c]) begin
                any      = 1'b1;
                idx      = c;
                grant[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_bram_rd_arbiter.sv
// Shares one BRAM read port among NUM_CH UART TX channels, one burst
// at a time, returning read data tagged with the owning channel.
module uart_bram_rd_arbiter
    import uart_bram_arb_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input logic clk,
    input logic rst,
    uart_bram_rd_arbiter_if.slave bus
);

    localparam int CH_W = ch_width(NUM_CH);

    arb_state_t state;
    arb_state_t state_nxt;

    logic [NUM_CH-1:0] sel_oh;
    logic [CH_W-1:0]   sel_ch;
    logic              sel_any;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;

    logic [NUM_CH-1:0] cur_oh;
    logic [CH_W-1:0]   cur_ch;
    logic [CH_W-1:0]   last_ch;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic              issue_last;

    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT-1:0] last_sr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_vld;
    logic [CH_W-1:0]   rd_ch;
    logic [NUM_CH-1:0] done_q;

    uart_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr (
        .req   (bus.i_Req),
        .last  (last_ch),
        .grant (sel_oh),
        .idx   (sel_ch),
        .any   (sel_any)
    );

    assign req_addr   = bus.i_Addr[sel_ch*ADDR_W +: ADDR_W];
    assign req_len    = bus.i_Len[sel_ch*LEN_W +: LEN_W];
    assign issue_last = (state == ISSUE) && (rem_q == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (sel_any)
                    state_nxt = (req_len == '0) ? ERR : ISSUE;
            end
            ISSUE: if (issue_last) state_nxt = DRAIN;
            DRAIN: if (done_q != '0) state_nxt = IDLE;
            ERR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.o_Grant     = '0;
        bus.o_Len_ERR   = '0;
        bus.o_BRAM_EN   = 1'b0;
        bus.o_BRAM_Addr = addr_q;
        unique case (state)
            ISSUE: begin
                bus.o_Grant   = cur_oh;
                bus.o_BRAM_EN = 1'b1;
            end
            DRAIN:   bus.o_Grant   = cur_oh;
            ERR:     bus.o_Len_ERR = cur_oh;
            default: ;
        endcase
    end

    // Burst bookkeeping plus the read-return pipeline. Only one burst is
    // ever in flight, so cur_ch is a valid tag for every returning word.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_oh  <= '0;
            cur_ch  <= '0;
            last_ch <= CH_W'(NUM_CH - 1);
            addr_q  <= '0;
            rem_q   <= '0;
            vld_sr  <= '0;
            last_sr <= '0;
            rd_data <= '0;
            rd_vld  <= 1'b0;
            rd_ch   <= '0;
            done_q  <= '0;
        end else begin
            if (state == IDLE && sel_any) begin
                cur_oh <= sel_oh;
                cur_ch <= sel_ch;
                addr_q <= req_addr;
                rem_q  <= req_len;
            end else if (state == ISSUE) begin
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - 1'b1;
            end
            if ((state == DRAIN && done_q != '0) || state == ERR)
                last_ch <= cur_ch;
            vld_sr[0]  <= (state == ISSUE);
            last_sr[0] <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
            rd_vld <= vld_sr[RD_LAT-1];
            if (vld_sr[RD_LAT-1]) begin
                rd_data <= bus.i_BRAM_Dout;
                rd_ch   <= cur_ch;
            end
            done_q <= last_sr[RD_LAT-1] ? cur_oh : '0;
        end
    end

    assign bus.o_Rd_Data = rd_data;
    assign bus.o_Rd_Vld  = rd_vld;
    assign bus.o_Rd_Ch   = rd_ch;
    assign bus.o_Done    = done_q;

endmodule
